axi_rdata_drain: RTL
====================

# axi_rdata_drain

Read-return engine of the AXI-to-SDRAM wrapper. It drains SDRAM read data from the read-side port of the clock-crossing FIFO and presents it on the AXI R channel with the correct burst length and `rlast`. It sits in the AXI clock domain, between the async FIFO's read port and the AXI slave front end. Commands (burst length) come from the AR-channel decoder.

## Interface

Parameters:
- `DATA_W`, 32, width of FIFO entries and `rdata`.
- `LEN_W`, 8, width of `cmd_len`; AXI-style, beats-1.

Ports:
- `clk`  in  1  single clock (AXI domain); also the FIFO read clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  burst command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_len`  in  LEN_W  beats-1 of the burst.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO pop request.
- `fifo_data`  in  DATA_W  FIFO registered output; valid the cycle after an accepted pop.
- `rdata`  out  DATA_W  AXI read data.
- `rresp`  out  2  AXI read response; constant 2'b00 (OKAY).
- `rvalid`  out  1  AXI read valid.
- `rready`  in  1  AXI read ready.
- `rlast`  out  1  last beat of the burst.
- `busy`  out  1  high while a burst is in progress.

## Operation

- FSM has two states, IDLE and BURST.
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch `pops_left = cmd_len+1` and `beats_left = cmd_len+1`, then go to BURST.
  - BURST: `cmd_ready`=0. Return to IDLE on the handshake (`rvalid && rready`) of the beat with `rlast`=1.
- Only one burst is outstanding at a time.
- Both counters are LEN_W+1 bits wide, so `cmd_len = 2^LEN_W-1` (256 beats at default) is legal.
- Output buffer: 2-entry FIFO holding `rdata`. `inflight` is a 1-bit register, set in the cycle after a pop.
- `fifo_rd_en = BURST && pops_left!=0 && !fifo_empty && (occ + inflight - (rvalid&&rready)) < 2`.
  - This is combinational from `rready`, which allows a sustained 1 beat/cycle.
  - Each pop decrements `pops_left`.
- A pop is never issued while `fifo_empty`=1, and never more than `cmd_len+1` pops per burst.
- `fifo_data` is written into the buffer in the cycle after the pop (`inflight`=1).
- `rvalid = occ != 0`. `rdata` is the buffer head.
- `rlast = rvalid && beats_left == 1`.
- Each R handshake decrements `beats_left`.
- AXI rule: once `rvalid` rises, `rvalid`, `rdata` and `rlast` stay stable until `rready`.
- FIFO underrun mid-burst: `rvalid` may drop only after the buffer empties. Data order is preserved with no duplication or loss.
- `busy` = (state == BURST).

## Timing

- Reset values (also driven while `reset`=1):
  - state IDLE, counters 0, `occ` 0, `inflight` 0.
  - `rvalid` 0, `rlast` 0, `rdata` 0, `rresp` 0, `fifo_rd_en` 0, `busy` 0, `cmd_ready` 0.
  - `cmd_ready` goes to 1 in the first cycle after `reset` deasserts.
- Reset mid-burst: all state is cleared on the next edge. Buffered and in-flight data are discarded. The FIFO is reset by the same system reset.
- Command latency, with the FIFO non-empty and `rready`=1:
  - cmd handshake at cycle N.
  - first `fifo_rd_en` at N+1.
  - first `rvalid` at N+3.
  - one beat per cycle thereafter.
  - `cmd_ready` high again the cycle after the last handshake.
- `cmd_len`=0: single beat with `rlast`=1; exactly one pop.
- `rready` low: at most 2 entries are buffered. Pops stop until space frees. No overflow; `inflight` data always has a free slot.
- A new command is accepted no earlier than the cycle after the burst's final handshake.

## Test plan

- Reset, then `cmd_len`=3, FIFO preloaded with 0xA0..0xA3, `rready`=1 -> four beats on consecutive cycles starting at N+3, `rlast` only on 0xA3, `cmd_ready` back to 1 at the following cycle.
- `cmd_len`=0, FIFO holds 0x55 -> one beat 0x55 with `rlast`=1, exactly one `fifo_rd_en` pulse.
- `cmd_len`=7, `rready` toggles 1/0 randomly -> eight beats in order, `rdata`/`rlast` stable while stalled, `occ` never exceeds 2, exactly 8 pops.
- `cmd_len`=4, FIFO empty for 10 cycles after 2 entries, then refilled -> no pop while `fifo_empty`, beats resume in order, total 5 beats, `rlast` on the 5th.
- `cmd_len`=255, continuous data with `rready`=1 -> 256 beats at 1 beat/cycle, `rlast` on beat 256, no extra pop.
- Assert `reset` mid-burst after beat 2 of 6 -> next cycle `rvalid`=0, `busy`=0, `fifo_rd_en`=0. After release, `cmd_ready`=1 and a new burst of `cmd_len`=1 completes correctly.

Source files
------------

// File: rtl/axi_rdata_drain.sv
// ---------------------------------------------------------------------------
// axi_rdata_drain
//
// Read-return engine of the AXI-to-SDRAM wrapper. It accepts one burst command
// at a time from the AR-channel decoder. It pops exactly cmd_len+1 words from
// the read port of the clock-crossing FIFO and returns them on the AXI R
// channel with the matching rlast.
//
// Ports
//   clk, reset       AXI-domain clock; synchronous active-high reset
//   cmd_valid/ready  burst command handshake, cmd_len = beats-1
//   fifo_empty       FIFO empty flag
//   fifo_rd_en       FIFO pop request
//   fifo_data        FIFO registered output, valid the cycle after a pop
//   rdata/rresp      AXI read data / response (always OKAY)
//   rvalid/rready    AXI read handshake
//   rlast            last beat of the burst
//   busy             burst in progress
// ---------------------------------------------------------------------------
module axi_rdata_drain #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              rlast,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Counters carry one extra bit so that a 2^LEN_W-beat burst fits.
  localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] CNT_ZERO = '0;

  state_t            state;
  state_t            state_next;
  logic [LEN_W:0]    pops_left;
  logic [LEN_W:0]    beats_left;

  // Two-entry output buffer; a pointer of one bit each is enough.
  logic [DATA_W-1:0] buf_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic              inflight;

  logic              r_hs;
  logic              cmd_hs;
  logic              last_hs;
  logic [2:0]        occ_after;

  // Outputs are forced to their idle values while reset is held. This way
  // nothing stale leaks out before the first reset edge clears the state.
  assign rresp   = 2'b00;
  assign rvalid  = (occ != 2'd0) && !reset;
  assign rdata   = reset ? '0 : buf_mem[rd_ptr];
  assign rlast   = rvalid && (beats_left == CNT_ONE);

  assign r_hs    = rvalid && rready;
  assign cmd_hs  = cmd_valid && cmd_ready;
  assign last_hs = r_hs && rlast;

  // Buffer occupancy this cycle's pop would see once the word in flight lands
  // and a beat leaves. Because this takes the current rready into account,
  // the engine can pop every cycle while the master keeps accepting beats.
  assign occ_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, r_hs};

  // A pop needs three things: pops still owed for the burst, data in the
  // FIFO, and a buffer slot guaranteed free when the word arrives next cycle.
  assign fifo_rd_en = busy && (pops_left != CNT_ZERO) && !fifo_empty &&
                      (occ_after < 3'd2);

  // State register for the burst FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode for the burst FSM. IDLE takes a command.
  // BURST lasts until the beat carrying rlast has been accepted.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
          state_next = BURST;
        end
      end
      BURST: begin
        busy = !reset;
        if (last_hs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Burst bookkeeping. pops_left limits the FIFO reads and beats_left
  // places rlast. Both are loaded only in IDLE and decremented only in BURST,
  // so the load and the decrements never happen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pops_left  <= '0;
      beats_left <= '0;
    end else if (cmd_hs) begin
      pops_left  <= {1'b0, cmd_len} + CNT_ONE;
      beats_left <= {1'b0, cmd_len} + CNT_ONE;
    end else begin
      if (fifo_rd_en) begin
        pops_left <= pops_left - CNT_ONE;
      end
      if (r_hs) begin
        beats_left <= beats_left - CNT_ONE;
      end
    end
  end

  // Output buffer. The FIFO presents data one cycle after a pop, so inflight
  // marks that cycle and the word is captured into the tail slot. The head
  // advances only on an R handshake, so rdata holds steady while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_mem[i] <= '0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        buf_mem[wr_ptr] <= fifo_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (r_hs) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_after[1:0];
    end
  end

endmodule
